// File: rtl/input_vc_arbiter_if.sv
// input_vc_arbiter_if: bundle between one input port's VC buffers, the
// crossbar and the per-port VC arbiter.
//
//   slave  modport : the arbiter (consumes has_packet/dest/cts/beat signals,
//                    produces the output request and the grant/pop strobes)
//   master modport : buffer + crossbar side (the environment)
//
// Handshake: a beat moves on a rising clk edge exactly when buf_valid and
// buf_ready are both 1; buf_ready is only ever 1 while grant is held, and
// neither side may make its half depend on seeing the other side's half in
// the same cycle except buf_ready = grant & out_ready.
interface input_vc_arbiter_if #(
  parameter int vc_num     = 3,
  parameter int prio_num   = 2,
  parameter int output_num = 8
);
  localparam int N  = vc_num * prio_num;
  localparam int VW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]                  has_packet;
  logic [N-1:0][output_num-1:0]  dest_i;
  logic [N-1:0][VW-1:0]          output_vc_i;
  logic                          cts;
  logic                          buf_valid;
  logic                          buf_last;
  logic                          out_ready;
  logic [output_num-1:0]         out_req;
  logic [VW-1:0]                 out_req_vc;
  logic [VW-1:0]                 selected_vc;
  logic                          grant;
  logic                          buf_ready;

  modport master (
    output has_packet, dest_i, output_vc_i, cts, buf_valid, buf_last, out_ready,
    input  out_req, out_req_vc, selected_vc, grant, buf_ready
  );

  modport slave (
    input  has_packet, dest_i, output_vc_i, cts, buf_valid, buf_last, out_ready,
    output out_req, out_req_vc, selected_vc, grant, buf_ready
  );
endinterface

// File: rtl/input_vc_arbiter.sv
// input_vc_arbiter: picks one of vc_num*prio_num virtual channels of an input
// port, requests its destination output/VC, waits for cts, then holds the
// grant until the packet's last beat. Strict priority between classes,
// round-robin inside a class, and a request timeout that masks a VC whose
// output never answers so the rest of the port is not blocked behind it.
//
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   bus           input_vc_arbiter_if.slave (VC status in, request/grant out)
//   dbg_state     FSM state (0 IDLE, 1 REQ, 2 XFER)
//   dbg_mask      per-VC timeout mask
//   dbg_rr_ptr    per-class round-robin pointer (last served VC in class)
module input_vc_arbiter #(
  parameter int vc_num      = 3,
  parameter int prio_num    = 2,
  parameter int output_num  = 8,
  parameter int REQ_TIMEOUT = 16,
  localparam int N  = vc_num * prio_num,
  localparam int PW = (vc_num > 1) ? $clog2(vc_num) : 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input_vc_arbiter_if.slave            bus,
  output logic [1:0]                   dbg_state,
  output logic [N-1:0]                 dbg_mask,
  output logic [prio_num-1:0][PW-1:0]  dbg_rr_ptr
);
  localparam int VW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(REQ_TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, XFER = 2'd2} state_t;

  state_t                       state, state_n;
  logic [VW-1:0]                sel_q, sel_n;
  logic [output_num-1:0]        req_q, req_n;
  logic [VW-1:0]                rvc_q, rvc_n;
  logic                         grant_q, grant_n;
  logic [TW-1:0]                tmo_q, tmo_n;
  logic [N-1:0]                 mask_q, mask_n;
  logic [prio_num-1:0][PW-1:0]  rr_q, rr_n;

  logic [N-1:0]                 eff_mask;
  logic [N-1:0]                 eligible;
  logic                         all_masked;
  logic                         any_elig;
  logic [VW-1:0]                win;
  logic                         found;
  logic [VW-1:0]                cand;
  int                           idx;
  logic                         beat;

  // When every VC holding a packet is masked, the mask is dropped in the
  // same cycle so a lone timed-out VC gets another try right away.
  always_comb begin
    all_masked = (|bus.has_packet) && ((bus.has_packet & ~mask_q) == '0);
    eff_mask   = all_masked ? '0 : mask_q;
    for (int i = 0; i < N; i++) begin
      eligible[i] = bus.has_packet[i] && $onehot(bus.dest_i[i]) && !eff_mask[i];
    end
  end

  // Classes are scanned low to high so a higher class overrides. Inside a
  // class the scan starts one past the last served VC.
  always_comb begin
    any_elig = 1'b0;
    win      = '0;
    found    = 1'b0;
    cand     = '0;
    idx      = 0;
    for (int c = 0; c < prio_num; c++) begin
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= vc_num; k++) begin
        idx = (int'(rr_q[c]) + k) % vc_num;
        if (!found && eligible[c*vc_num + idx]) begin
          found = 1'b1;
          cand  = VW'(c*vc_num + idx);
        end
      end
      if (found) begin
        any_elig = 1'b1;
        win      = cand;
      end
    end
  end

  assign beat = bus.buf_valid && grant_q && bus.out_ready;

  always_comb begin
    state_n = state;
    sel_n   = sel_q;
    req_n   = req_q;
    rvc_n   = rvc_q;
    grant_n = grant_q;
    tmo_n   = tmo_q;
    mask_n  = eff_mask;
    rr_n    = rr_q;
    case (state)
      IDLE: begin
        if (any_elig) begin
          sel_n   = win;
          req_n   = bus.dest_i[win];
          rvc_n   = bus.output_vc_i[win];
          tmo_n   = '0;
          state_n = REQ;
        end
      end
      REQ: begin
        if (bus.cts) begin
          req_n   = '0;
          rvc_n   = '0;
          grant_n = 1'b1;
          state_n = XFER;
        end else if (!bus.has_packet[sel_q]) begin
          req_n   = '0;
          rvc_n   = '0;
          state_n = IDLE;
        end else if (tmo_q == TW'(REQ_TIMEOUT - 1)) begin
          mask_n[sel_q] = 1'b1;
          req_n         = '0;
          rvc_n         = '0;
          state_n       = IDLE;
        end else begin
          tmo_n = tmo_q + TW'(1);
        end
      end
      XFER: begin
        if (beat && bus.buf_last) begin
          grant_n = 1'b0;
          mask_n  = '0;
          state_n = IDLE;
          for (int c = 0; c < prio_num; c++) begin
            if (int'(sel_q) / vc_num == c) rr_n[c] = PW'(int'(sel_q) % vc_num);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      sel_q   <= '0;
      req_q   <= '0;
      rvc_q   <= '0;
      grant_q <= 1'b0;
      tmo_q   <= '0;
      mask_q  <= '0;
      for (int c = 0; c < prio_num; c++) rr_q[c] <= PW'(vc_num - 1);
    end else begin
      state   <= state_n;
      sel_q   <= sel_n;
      req_q   <= req_n;
      rvc_q   <= rvc_n;
      grant_q <= grant_n;
      tmo_q   <= tmo_n;
      mask_q  <= mask_n;
      rr_q    <= rr_n;
    end
  end

  assign bus.out_req     = req_q;
  assign bus.out_req_vc  = rvc_q;
  assign bus.selected_vc = sel_q;
  assign bus.grant       = grant_q;
  assign bus.buf_ready   = grant_q & bus.out_ready;

  assign dbg_state  = state;
  assign dbg_mask   = mask_q;
  assign dbg_rr_ptr = rr_q;
endmodule
